// File: rtl/prog_sequencer.sv
// Program sequencer: replays a small program RAM into the CPU's DIN/run/done
// handshake, presenting move-immediate operands and timing out on a stalled CPU.
module prog_sequencer #(
  parameter int unsigned CMD_LENGTH = 6,
  parameter int unsigned ADDR_W     = 4,
  parameter logic [1:0]  MVI_OP     = 2'b01,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ld_we,
  input  logic [ADDR_W-1:0]     ld_addr,
  input  logic [CMD_LENGTH-1:0] ld_data,
  input  logic [ADDR_W:0]       prog_len,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  done,
  output logic [CMD_LENGTH-1:0] din,
  output logic                  run,
  output logic [ADDR_W-1:0]     pc,
  output logic                  busy,
  output logic                  halted,
  output logic                  err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_IMM, S_WAIT, S_HALT, S_ERR} state_t;

  state_t                state_q, state_d;
  logic [CMD_LENGTH-1:0] din_q, din_d;
  logic                  run_q, run_d;
  logic                  busy_q, busy_d;
  logic                  halted_q, halted_d;
  logic                  err_q, err_d;
  logic [ADDR_W-1:0]     pc_q, pc_d;
  logic [ADDR_W:0]       len_q, len_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  stop_seen_q, stop_seen_d;

  logic [CMD_LENGTH-1:0] mem [DEPTH];

  logic                  wr_en;
  logic                  stop_any;
  logic [ADDR_W:0]       pc_nxt;
  logic [CMD_LENGTH-1:0] word0;
  logic [CMD_LENGTH-1:0] word_nxt;

  assign wr_en    = ld_we && (state_q inside {S_IDLE, S_HALT, S_ERR});
  assign stop_any = stop_seen_q | stop;
  assign pc_nxt   = {1'b0, pc_q} + {{ADDR_W{1'b0}}, 1'b1};
  // A write landing in the same cycle as start must already be visible at address 0
  assign word0    = (wr_en && ld_addr == '0) ? ld_data : mem[0];
  assign word_nxt = mem[pc_nxt[ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) mem[ld_addr] <= ld_data;
  end

  always_comb begin
    state_d     = state_q;
    din_d       = din_q;
    run_d       = 1'b0;
    pc_d        = pc_q;
    len_d       = len_q;
    timer_d     = timer_q;
    stop_seen_d = stop_seen_q;

    case (state_q)
      S_IDLE, S_HALT, S_ERR: begin
        if (start) begin
          len_d = prog_len;
          pc_d  = '0;
          if (prog_len == '0) begin
            state_d = S_HALT;
            din_d   = '0;
          end else begin
            state_d = S_ISSUE;
            din_d   = word0;
            run_d   = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        timer_d     = '0;
        stop_seen_d = stop;
        if (din_q[CMD_LENGTH-1 -: 2] == MVI_OP && pc_nxt < len_q) begin
          pc_d    = pc_nxt[ADDR_W-1:0];
          din_d   = word_nxt;
          state_d = S_IMM;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_IMM, S_WAIT: begin
        stop_seen_d = stop_any;
        if (done) begin
          if (stop_any) begin
            state_d = S_IDLE;
            din_d   = '0;
          end else if (pc_nxt == len_q) begin
            state_d = S_HALT;
            din_d   = '0;
          end else begin
            pc_d    = pc_nxt[ADDR_W-1:0];
            din_d   = word_nxt;
            run_d   = 1'b1;
            state_d = S_ISSUE;
          end
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = S_ERR;
          din_d   = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        din_d   = '0;
      end
    endcase

    busy_d   = state_d inside {S_ISSUE, S_IMM, S_WAIT};
    halted_d = (state_d == S_HALT);
    err_d    = (state_d == S_ERR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      din_q       <= '0;
      run_q       <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
      err_q       <= 1'b0;
      pc_q        <= '0;
      len_q       <= '0;
      timer_q     <= '0;
      stop_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      din_q       <= din_d;
      run_q       <= run_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
      err_q       <= err_d;
      pc_q        <= pc_d;
      len_q       <= len_d;
      timer_q     <= timer_d;
      stop_seen_q <= stop_seen_d;
    end
  end

  assign din    = din_q;
  assign run    = run_q;
  assign pc     = pc_q;
  assign busy   = busy_q;
  assign halted = halted_q;
  assign err    = err_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: a cycle-stepping CPU responder plus an
// instruction-list reference derived from the program contents and length.
module tb_prog_sequencer;

  localparam int unsigned CL = 6;
  localparam int unsigned AW = 4;
  localparam int unsigned TO = 15;
  localparam logic [1:0]  MVI = 2'b01;

  logic          clk = 1'b0;
  logic          reset, ld_we, start, stop, done;
  logic [AW-1:0] ld_addr;
  logic [CL-1:0] ld_data;
  logic [AW:0]   prog_len;
  logic [CL-1:0] din;
  logic          run, busy, halted, err;
  logic [AW-1:0] pc;

  int total = 0;
  int bad   = 0;
  logic [CL-1:0] mdl [16];

  always #5 clk = ~clk;

  prog_sequencer #(
    .CMD_LENGTH(CL),
    .ADDR_W    (AW),
    .MVI_OP    (MVI),
    .TIMEOUT   (TO)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ld_we   (ld_we),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .prog_len(prog_len),
    .start   (start),
    .stop    (stop),
    .done    (done),
    .din     (din),
    .run     (run),
    .pc      (pc),
    .busy    (busy),
    .halted  (halted),
    .err     (err)
  );

  function automatic bit is_mvi(input logic [CL-1:0] w);
    return w[CL-1 -: 2] == MVI;
  endfunction

  task automatic load_word(input int unsigned a, input logic [CL-1:0] d);
    ld_we   = 1'b1;
    ld_addr = a[AW-1:0];
    ld_data = d;
    @(negedge clk);
    ld_we   = 1'b0;
    mdl[a]  = d;
  endtask

  // Starts a program and plays the CPU (done dly cycles after each run);
  // inject=1 tries a write and a restart while the first instruction is in flight.
  task automatic run_and_check(input string name, input int unsigned len,
                               input int unsigned dly, input bit inject);
    logic [CL-1:0] exp_w[$];
    logic [CL-1:0] exp_i[$];
    bit            exp_h[$];
    int            exp_pc[$];
    int  i = 0, idx = 0, since = -1, follow = -1, inj = 0;
    bit  fin = 1'b0;
    while (i < int'(len)) begin
      exp_w.push_back(mdl[i]);
      exp_pc.push_back(i);
      if (is_mvi(mdl[i]) && i + 1 < int'(len)) begin
        exp_h.push_back(1'b1); exp_i.push_back(mdl[i+1]); i += 2;
      end else begin
        exp_h.push_back(1'b0); exp_i.push_back('0); i += 1;
      end
    end
    prog_len = len[AW:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      if (follow >= 0) begin
        total++;
        if (exp_h[follow]) begin
          if (run !== 1'b0 || din !== exp_i[follow] || pc !== AW'(exp_pc[follow] + 1)) begin
            bad++;
            $display("FAIL %s imm[%0d]: run=%0b din=%h pc=%0d, expected run=0 din=%h pc=%0d",
                     name, follow, run, din, pc, exp_i[follow], exp_pc[follow] + 1);
          end
        end else if (run !== 1'b0 || din !== exp_w[follow] || pc !== AW'(exp_pc[follow])) begin
          bad++;
          $display("FAIL %s hold[%0d]: run=%0b din=%h pc=%0d, expected run=0 din=%h pc=%0d",
                   name, follow, run, din, pc, exp_w[follow], exp_pc[follow]);
        end
        if (inject && follow == 0) inj = 1;
        follow = -1;
      end
      if (run === 1'b1) begin
        total++;
        if (idx >= exp_w.size()) begin
          bad++;
          $display("FAIL %s extra_run: got run #%0d din=%h, expected only %0d runs",
                   name, idx, din, exp_w.size());
        end else begin
          if (din !== exp_w[idx] || pc !== AW'(exp_pc[idx])) begin
            bad++;
            $display("FAIL %s issue[%0d]: din=%h pc=%0d, expected din=%h pc=%0d",
                     name, idx, din, pc, exp_w[idx], exp_pc[idx]);
          end
          follow = idx;
        end
        idx++;
        since = 0;
      end else if (since >= 0) begin
        since++;
      end
      done = (since == int'(dly));
      if (since == int'(dly)) since = -1;
      if (inj == 1) begin
        ld_we = 1'b1; ld_addr = 4'd1; ld_data = 6'h3F; prog_len = '0; inj = 2;
      end else if (inj == 2) begin
        ld_we = 1'b0; start = 1'b1; inj = 3;
      end else if (inj == 3) begin
        start = 1'b0; inj = 4;
      end
      if (halted === 1'b1) fin = 1'b1;
      else @(negedge clk);
    end
    done = 1'b0;
    total++;
    if (!fin) begin
      bad++;
      $display("FAIL %s halt_timeout: halted=%0b busy=%0b err=%0b, expected halted=1",
               name, halted, busy, err);
    end
    total++;
    if (idx != exp_w.size() || pc !== AW'(len - 1) || din !== '0) begin
      bad++;
      $display("FAIL %s final: runs=%0d pc=%0d din=%h, expected runs=%0d pc=%0d din=00",
               name, idx, pc, din, exp_w.size(), len - 1);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (din !== '0 || run !== 1'b0 || pc !== '0 || busy !== 1'b0 || halted !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: din=%h run=%0b pc=%0d busy=%0b halted=%0b err=%0b, expected all 0",
               din, run, pc, busy, halted, err);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    load_word(0, 6'h05); load_word(1, 6'h16); load_word(2, 6'h3A); load_word(3, 6'h21);
    run_and_check("basic", 4, 3, 1'b0);
  endtask

  task automatic test_mvi;
    load_word(0, 6'h14); load_word(1, 6'h2B); load_word(2, 6'h09);
    run_and_check("mvi", 3, 3, 1'b0);
    load_word(0, 6'h05); load_word(1, 6'h15);
    run_and_check("mvi_last", 2, 2, 1'b0);
  endtask

  task automatic test_timeout;
    load_word(0, 6'h05);
    prog_len = 5'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (run !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL to_issue: run=%0b busy=%0b, expected 1 1", run, busy);
    end
    @(negedge clk);
    for (int k = 1; k <= int'(TO); k++) begin
      @(negedge clk);
      if (k == int'(TO) - 1) begin
        total++;
        if (err !== 1'b0 || busy !== 1'b1) begin
          bad++;
          $display("FAIL to_early: err=%0b busy=%0b at cycle %0d, expected err=0 busy=1", err, busy, k);
        end
      end
    end
    total++;
    if (err !== 1'b1 || pc !== '0 || din !== '0 || busy !== 1'b0 || run !== 1'b0) begin
      bad++;
      $display("FAIL to_err: err=%0b pc=%0d din=%h busy=%0b run=%0b, expected 1 0 00 0 0",
               err, pc, din, busy, run);
    end
    load_word(0, 6'h0A);
    run_and_check("after_err", 1, 2, 1'b0);
  endtask

  task automatic test_busy_ignore;
    load_word(0, 6'h05); load_word(1, 6'h0C); load_word(2, 6'h22);
    run_and_check("busy_ignore", 3, 3, 1'b1);
  endtask

  task automatic test_full_len;
    logic [CL-1:0] w;
    for (int a = 0; a < 16; a++) begin
      w = CL'($urandom);
      if (is_mvi(w)) w[CL-1] = 1'b1;
      load_word(a, w);
    end
    run_and_check("full_len", 16, 2, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (run !== 1'b0 || halted !== 1'b1) begin
        bad++;
        $display("FAIL full_len_after: run=%0b halted=%0b, expected 0 1", run, halted);
      end
    end
  endtask

  task automatic test_len_zero;
    prog_len = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (halted !== 1'b1 || run !== 1'b0 || busy !== 1'b0 || din !== '0) begin
      bad++;
      $display("FAIL len_zero: halted=%0b run=%0b busy=%0b din=%h, expected 1 0 0 00",
               halted, run, busy, din);
    end
  endtask

  task automatic test_start_write;
    ld_we = 1'b1; ld_addr = '0; ld_data = 6'h07;
    prog_len = 5'd1; start = 1'b1;
    mdl[0] = 6'h07;
    @(negedge clk);
    ld_we = 1'b0; start = 1'b0;
    total++;
    if (run !== 1'b1 || din !== mdl[0]) begin
      bad++;
      $display("FAIL start_write: run=%0b din=%h, expected run=1 din=%h", run, din, mdl[0]);
    end
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    total++;
    if (halted !== 1'b1) begin
      bad++;
      $display("FAIL start_write_halt: halted=%0b, expected 1", halted);
    end
  endtask

  task automatic test_stop;
    load_word(0, 6'h05); load_word(1, 6'h0C); load_word(2, 6'h22); load_word(3, 6'h23);
    prog_len = 5'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    total++;
    if (busy !== 1'b0 || halted !== 1'b0 || err !== 1'b0 || din !== '0 || run !== 1'b0) begin
      bad++;
      $display("FAIL stop_idle: busy=%0b halted=%0b err=%0b din=%h run=%0b, expected all 0",
               busy, halted, err, din, run);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (run !== 1'b0) begin
        bad++;
        $display("FAIL stop_norun: run=%0b, expected 0", run);
      end
    end
  endtask

  task automatic test_random;
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < 16; a++) load_word(a, CL'($urandom));
      run_and_check("random", $urandom_range(1, 16), $urandom_range(1, 4), 1'b0);
    end
  endtask

  task automatic test_async_reset;
    load_word(0, 6'h14); load_word(1, 6'h2B);
    prog_len = 5'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    total++;
    if (din !== 6'h2B || run !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL areset_imm: din=%h run=%0b busy=%0b, expected 2b 0 1", din, run, busy);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (din !== '0 || run !== 1'b0 || pc !== '0 || busy !== 1'b0 || halted !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL areset_now: din=%h run=%0b pc=%0d busy=%0b halted=%0b err=%0b, expected all 0",
               din, run, pc, busy, halted, err);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ld_we = 1'b0; start = 1'b0; stop = 1'b0; done = 1'b0;
    ld_addr = '0; ld_data = '0; prog_len = '0;
    test_reset();
    test_basic();
    test_mvi();
    test_timeout();
    test_busy_ignore();
    test_full_len();
    test_len_zero();
    test_start_write();
    test_stop();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
